// File: rtl/sram_arbiter_pkg.sv
// sram_arb_pkg: shared constants for the SRAM arbiter (state encoding, requester ids, default widths)
package sram_arb_pkg;
    localparam int AW_DEF = 19;
    localparam int DW_DEF = 8;
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD       = 3'd1;
    localparam logic [2:0] ST_WR_SETUP = 3'd2;
    localparam logic [2:0] ST_WR_PULSE = 3'd3;
    localparam logic [2:0] ST_WR_HOLD  = 3'd4;
    localparam logic [2:0] ST_ACK      = 3'd5;
    localparam logic REQ_VID = 1'b0;
    localparam logic REQ_CPU = 1'b1;
endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: video and CPU request/acknowledge bundle between requesters and the SRAM arbiter
interface sram_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic [DW-1:0] vid_data;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic          cpu_ack;
    logic [DW-1:0] cpu_dout;
    modport master (
        output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din,
        input  vid_ack, vid_data, cpu_ack, cpu_dout
    );
    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din,
        output vid_ack, vid_data, cpu_ack, cpu_dout
    );
endinterface

// File: rtl/sram_arbiter_prio.sv
// sram_arb_prio: video-first winner selection with a saturating CPU starvation counter
module sram_arb_prio
    import sram_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic idle,
    input  logic vid_req,
    input  logic cpu_req,
    output logic grant,
    output logic winner
);
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);
    logic [3:0] starve_cnt;
    // CPU only overtakes a pending video request once video has had SMAX grants in a row
    always_comb begin
        grant  = idle && (vid_req || cpu_req);
        winner = (cpu_req && (!vid_req || starve_cnt == SMAX)) ? REQ_CPU : REQ_VID;
    end
    // count video grants made while the CPU waits; clear when the CPU wins or stops asking
    always_ff @(posedge clk) begin
        if (!rst_n)
            starve_cnt <= '0;
        else if (idle) begin
            if (!cpu_req || winner == REQ_CPU)
                starve_cnt <= '0;
            else if (vid_req && starve_cnt != SMAX)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: serialises video reads and CPU reads/writes onto the single external SRAM
// Build option: define SRAM_ARB_WRITE_HOLD_EN to hold address/data one cycle after sram_we_n rises.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int CPU_STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    sram_arbiter_if.slave bus,
    output logic [AW-1:0] sram_addr,
    inout  wire  [DW-1:0] sram_data,
    output logic          sram_we_n
);
    logic [2:0]    state, state_nx;
    logic          owner, grant, winner, idle, data_oe;
    logic [DW-1:0] wdata;

    assign idle      = state == ST_IDLE;
    assign data_oe   = state == ST_WR_SETUP || state == ST_WR_PULSE || state == ST_WR_HOLD;
    assign sram_data = data_oe ? wdata : 'z;

    sram_arb_prio #(.STARVE_MAX(CPU_STARVE_MAX)) u_prio (
        .clk     (clk),
        .rst_n   (rst_n),
        .idle    (idle),
        .vid_req (bus.vid_req),
        .cpu_req (bus.cpu_req),
        .grant   (grant),
        .winner  (winner)
    );

    // access sequencing: reads take one bus cycle, writes frame the strobe with setup (and optional hold)
    always_comb begin
        state_nx = ST_IDLE;
        case (state)
            ST_IDLE:     state_nx = !grant ? ST_IDLE : (winner == REQ_CPU && bus.cpu_we) ? ST_WR_SETUP : ST_RD;
            ST_RD:       state_nx = ST_ACK;
            ST_WR_SETUP: state_nx = ST_WR_PULSE;
`ifdef SRAM_ARB_WRITE_HOLD_EN
            ST_WR_PULSE: state_nx = ST_WR_HOLD;
            ST_WR_HOLD:  state_nx = ST_ACK;
`else
            ST_WR_PULSE: state_nx = ST_ACK;
`endif
            default:     state_nx = ST_IDLE;
        endcase
    end

    // registered SRAM controls, grant latches, read capture and ack pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            owner        <= REQ_VID;
            wdata        <= '0;
            sram_addr    <= '0;
            sram_we_n    <= 1'b1;
            bus.vid_ack  <= 1'b0;
            bus.cpu_ack  <= 1'b0;
            bus.vid_data <= '1;
            bus.cpu_dout <= '1;
        end else begin
            state       <= state_nx;
            sram_we_n   <= state_nx != ST_WR_PULSE;
            bus.vid_ack <= state_nx == ST_ACK && owner == REQ_VID;
            bus.cpu_ack <= state_nx == ST_ACK && owner == REQ_CPU;
            if (grant) begin
                owner     <= winner;
                sram_addr <= winner == REQ_CPU ? bus.cpu_addr : bus.vid_addr;
                wdata     <= bus.cpu_din;
            end
            if (state == ST_RD && owner == REQ_VID)
                bus.vid_data <= sram_data;
            if (state == ST_RD && owner == REQ_CPU)
                bus.cpu_dout <= sram_data;
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed vectors, corner sequences and random traffic against a cycle-budget model
module tb_sram_arbiter;
    import sram_arb_pkg::*;
    localparam int AW = 19;
    localparam int DW = 8;
    localparam int SMAX = 4;
`ifdef SRAM_ARB_WRITE_HOLD_EN
    localparam int WLEN = 5;
`else
    localparam int WLEN = 4;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    wire  [DW-1:0] sram_data;
    logic [AW-1:0] sram_addr;
    logic          sram_we_n;
    logic [DW-1:0] rd_drv = '0;
    logic [7:0] mem [logic [18:0]];
    logic [7:0] pre [logic [18:0]];
    int wcnt = 0;
    logic [18:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    int n_cmp = 0;
    int n_bad = 0;

    sram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    sram_arbiter #(.AW(AW), .DW(DW), .CPU_STARVE_MAX(SMAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .sram_addr (sram_addr),
        .sram_data (sram_data),
        .sram_we_n (sram_we_n)
    );

    always #5 clk = ~clk;

    assign sram_data = dut.data_oe ? 'z : rd_drv;

    function automatic logic [7:0] pat(input logic [18:0] a);
        return a[7:0] ^ {a[18:15], a[11:8]};
    endfunction

    function automatic logic [7:0] rdmem(input logic [18:0] a);
        return mem.exists(a) ? mem[a] : pre.exists(a) ? pre[a] : pat(a);
    endfunction

    // SRAM model: write on every edge that sees the strobe low
    always @(posedge clk) begin
        if (rst_n && !sram_we_n) begin
            mem[sram_addr] = sram_data;
            wcnt = wcnt + 1;
            wr_addr = sram_addr;
            wr_data = sram_data;
        end
    end

    always @(negedge clk) rd_drv <= rdmem(sram_addr);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic xact(input logic cpu, input logic we, input logic [18:0] a, input logic [7:0] d,
                        output int lat, output logic [7:0] q);
        lat = -1;
        if (cpu) begin
            bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_din = d;
        end else begin
            bus.vid_req = 1'b1; bus.vid_addr = a;
        end
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(negedge clk);
            if (cpu ? bus.cpu_ack : bus.vid_ack) lat = i;
        end
        q = cpu ? bus.cpu_dout : bus.vid_data;
        bus.cpu_req = 1'b0;
        bus.vid_req = 1'b0;
        @(negedge clk);
        check("ack_one_cycle", 32'(bus.cpu_ack | bus.vid_ack), 32'd0);
    endtask

    typedef struct {
        logic        cpu;
        logic        we;
        logic [18:0] addr;
        logic [7:0]  din;
        int          lat;
        logic [7:0]  q;
    } vec_t;

    vec_t vt [8];
    int lat, t_v, t_c, nack, w0, edge_no, t_free, ack_e, starve, len;
    logic [7:0] q, m_vid, m_cpu;
    logic [6:0] seq;
    logic found, acc, g_cpu, g_we;
    logic [18:0] a;
    logic [7:0] ref_mem [64];

    initial begin
        bus.vid_req = 1'b1; bus.vid_addr = '0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = '0; bus.cpu_din = 8'h77;
        pre[19'h0A000] = 8'h5C;
        pre[19'h00000] = 8'hC3;

        // reset with both requests pending
        repeat (2) @(negedge clk);
        check("rst_vid_ack", 32'(bus.vid_ack), 32'd0);
        check("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_bus_z", 32'(dut.data_oe), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_vid_data", 32'(bus.vid_data), 32'hFF);
        check("rst_cpu_dout", 32'(bus.cpu_dout), 32'hFF);
        bus.vid_req = 1'b0; bus.cpu_req = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // single-requester vectors
        vt[0] = '{1'b0, 1'b0, 19'h0A000, 8'h00, 2, 8'h5C};
        vt[1] = '{1'b1, 1'b1, 19'h12345, 8'hA5, WLEN - 1, 8'hFF};
        vt[2] = '{1'b1, 1'b0, 19'h12345, 8'h00, 2, 8'hA5};
        vt[3] = '{1'b0, 1'b0, 19'h12345, 8'h00, 2, 8'hA5};
        vt[4] = '{1'b1, 1'b1, 19'h7FFFF, 8'h3C, WLEN - 1, 8'hA5};
        vt[5] = '{1'b0, 1'b0, 19'h7FFFF, 8'h00, 2, 8'h3C};
        vt[6] = '{1'b1, 1'b0, 19'h00000, 8'h00, 2, 8'hC3};
        vt[7] = '{1'b0, 1'b0, 19'h0A000, 8'h00, 2, 8'h5C};
        for (int i = 0; i < 8; i++) begin
            w0 = wcnt;
            xact(vt[i].cpu, vt[i].we, vt[i].addr, vt[i].din, lat, q);
            check($sformatf("vec%0d_latency", i), lat, vt[i].lat);
            check($sformatf("vec%0d_data", i), 32'(q), 32'(vt[i].q));
            if (vt[i].we) begin
                check($sformatf("vec%0d_we_pulses", i), wcnt - w0, 1);
                check($sformatf("vec%0d_wr_addr", i), 32'(wr_addr), 32'(vt[i].addr));
                check($sformatf("vec%0d_wr_data", i), 32'(wr_data), 32'(vt[i].din));
            end
        end

        // simultaneous first request: video first, CPU on the next grant
        bus.vid_req = 1'b1; bus.vid_addr = 19'h0A000;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 19'h12345;
        t_v = -1; t_c = -1;
        for (int i = 1; i <= 20 && t_c < 0; i++) begin
            @(negedge clk);
            if (bus.vid_ack) begin if (t_v < 0) t_v = i; bus.vid_req = 1'b0; end
            if (bus.cpu_ack) begin t_c = i; bus.cpu_req = 1'b0; end
        end
        bus.vid_req = 1'b0; bus.cpu_req = 1'b0;
        check("sim_vid_ack_time", t_v, 2);
        check("sim_cpu_ack_time", t_c, 5);
        check("sim_cpu_data", 32'(bus.cpu_dout), 32'hA5);
        @(negedge clk);

        // starvation: continuous video, CPU gets the fifth grant
        bus.vid_req = 1'b1; bus.vid_addr = 19'h0A000;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 19'h7FFFF;
        seq = '0; nack = 0;
        for (int i = 0; i < 60 && nack < 7; i++) begin
            @(negedge clk);
            if (bus.vid_ack && nack < 7) begin seq[nack] = 1'b0; nack++; end
            if (bus.cpu_ack && nack < 7) begin seq[nack] = 1'b1; nack++; bus.cpu_req = 1'b0; end
        end
        bus.vid_req = 1'b0; bus.cpu_req = 1'b0;
        check("starve_ack_count", nack, 7);
        check("starve_order", 32'(seq), 32'(7'b0010000));
        check("starve_cpu_data", 32'(bus.cpu_dout), 32'h3C);
        repeat (2) @(negedge clk);

        // reset while the write strobe is low
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 19'h00055; bus.cpu_din = 8'h99;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = !sram_we_n;
        end
        check("rstw_pulse_seen", 32'(found), 32'd1);
        rst_n = 1'b0; bus.cpu_req = 1'b0;
        @(negedge clk);
        check("rstw_we_n", 32'(sram_we_n), 32'd1);
        check("rstw_cpu_ack", 32'(bus.cpu_ack), 32'd0);
        check("rstw_state_idle", 32'(dut.state), 32'(ST_IDLE));
        check("rstw_bus_z", 32'(dut.data_oe), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        acc = 1'b0;
        repeat (4) begin @(negedge clk); acc = acc | bus.cpu_ack; end
        check("rstw_no_ack", 32'(acc), 32'd0);

        // random traffic against a grant/duration model
        for (int i = 0; i < 64; i++) ref_mem[i] = rdmem(19'h40000 + 19'(i));
        edge_no = 0; t_free = 0; ack_e = -1; starve = 0;
        g_cpu = 1'b0; g_we = 1'b0; m_vid = 8'hFF; m_cpu = 8'hFF;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            if (edge_no >= t_free) begin
                if (!bus.cpu_req) starve = 0;
                if (bus.vid_req || bus.cpu_req) begin
                    g_cpu = bus.cpu_req && (!bus.vid_req || starve == SMAX);
                    g_we = g_cpu && bus.cpu_we;
                    if (g_cpu) starve = 0;
                    else if (bus.cpu_req) starve = starve < SMAX ? starve + 1 : SMAX;
                    a = g_cpu ? bus.cpu_addr : bus.vid_addr;
                    len = g_we ? WLEN : 3;
                    if (g_we) ref_mem[a[5:0]] = bus.cpu_din;
                    else if (g_cpu) m_cpu = ref_mem[a[5:0]];
                    else m_vid = ref_mem[a[5:0]];
                    ack_e = edge_no + len - 2;
                    t_free = edge_no + len;
                end
            end
            @(negedge clk);
            check("rnd_vid_ack", 32'(bus.vid_ack), 32'(ack_e == edge_no && !g_cpu));
            check("rnd_cpu_ack", 32'(bus.cpu_ack), 32'(ack_e == edge_no && g_cpu));
            if (ack_e == edge_no && !g_cpu) check("rnd_vid_data", 32'(bus.vid_data), 32'(m_vid));
            if (ack_e == edge_no && g_cpu && !g_we) check("rnd_cpu_data", 32'(bus.cpu_dout), 32'(m_cpu));
            edge_no++;
            if (bus.vid_ack) bus.vid_req = 1'b0;
            else if (!bus.vid_req && $urandom_range(0, 2) != 0) begin
                bus.vid_req = 1'b1;
                bus.vid_addr = 19'h40000 | 19'($urandom_range(0, 63));
            end
            if (bus.cpu_ack) bus.cpu_req = 1'b0;
            else if (!bus.cpu_req && $urandom_range(0, 3) == 0) begin
                bus.cpu_req = 1'b1;
                bus.cpu_we = 1'($urandom_range(0, 1));
                bus.cpu_addr = 19'h40000 | 19'($urandom_range(0, 63));
                bus.cpu_din = 8'($urandom);
            end
        end
        bus.vid_req = 1'b0; bus.cpu_req = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 64; i++)
            check($sformatf("rnd_mem_%0d", i), 32'(rdmem(19'h40000 + 19'(i))), 32'(ref_mem[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
